// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte out on device-generated clocks and checks the ack.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int START_HOLD     = 25,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int HOLD_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
  localparam int CW       = $clog2(HOLD_MAX + 1);
  localparam int WW       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state;
  logic [2:0]      clk_sync;   // [0] first stage, [1] current, [2] previous
  logic [1:0]      data_sync;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   wdog;
  logic [3:0]      idx;
  logic [8:0]      frame;      // {parity, data}

  logic clk_fall;
  logic clk_s;
  logic data_s;
  logic wd_active;
  logic wd_expired;

  assign clk_s      = clk_sync[1];
  assign data_s     = data_sync[1];
  assign clk_fall   = (clk_sync[2:1] == 2'b10);
  assign wd_active  = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign wd_expired = (wdog == WW'(TIMEOUT_CYCLES - 1));

  // Reset to the idle (high) bus level so leaving reset never fakes a falling edge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // NOTE: every register here uses <= so all branches see pre-edge values of
  // state/idx/wdog; a blocking write would leak into later reads in this block.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      cnt         <= '0;
      wdog        <= '0;
      idx         <= '0;
      frame       <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;

      // Expiry wins over any same-cycle ack edge.
      if (wd_active && wd_expired) begin
        state       <= S_IDLE;
        tx_ready    <= 1'b1;
        tx_err      <= 1'b1;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
      end else begin
        if (wd_active) wdog <= wdog + 1'b1;

        case (state)
          S_IDLE: begin
            if (tx_valid) begin
              frame      <= {~^tx_data, tx_data};
              tx_ready   <= 1'b0;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
              state      <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_START: begin
            if (cnt == CW'(START_HOLD - 1)) begin
              ps2_clk_oe <= 1'b0;
              idx        <= '0;
              wdog       <= '0;
              state      <= S_SEND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          S_SEND: begin
            if (clk_fall) begin
              idx <= idx + 1'b1;
              if (idx == 4'd9) begin
                ps2_data_oe <= 1'b0;
                state       <= S_ACK;
              end else begin
                ps2_data_oe <= ~frame[idx];
              end
            end
          end

          S_ACK: begin
            if (clk_fall) begin
              if (!data_s) tx_done <= 1'b1;
              else         tx_err  <= 1'b1;
              state <= S_WAIT_IDLE;
            end
          end

          S_WAIT_IDLE: begin
            if (clk_s && data_s) begin
              tx_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end

          default: begin
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT;
// expected outcomes are queued at send time and checked when tx_done/tx_err fire.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INHIBIT = 2500;
  localparam int HOLD    = 25;
  localparam int TMO     = 26000;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       clk_line, data_line;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .START_HOLD    (HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #20 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- device model ----------------
  typedef enum int {DEV_ACK, DEV_NACK, DEV_NEVER} dev_mode_t;
  dev_mode_t   dev_mode    = DEV_ACK;
  int          half        = 50;
  int          stop_after  = 10;
  logic        dev_busy    = 1'b0;
  logic        dev_aborted = 1'b0;
  logic [10:0] dev_bits    = '0;
  int          dev_frames  = 0;

  task automatic run_frame();
    logic [10:0] bits;
    bits     = '0;
    dev_busy = 1'b1;
    bits[0]  = data_line;
    repeat (half) @(negedge vga_clk);
    for (int i = 1; i <= 10; i++) begin
      if (i > stop_after) begin
        dev_aborted = 1'b1;
        dev_busy    = 1'b0;
        return;
      end
      dev_clk_low = 1'b1;
      repeat (half) @(negedge vga_clk);
      bits[i]     = data_line;
      dev_clk_low = 1'b0;
      repeat (half) @(negedge vga_clk);
    end
    dev_bits = bits;
    if (dev_mode == DEV_ACK) dev_data_low = 1'b1;
    repeat (half / 2) @(negedge vga_clk);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge vga_clk);
    dev_clk_low = 1'b0;
    repeat (half) @(negedge vga_clk);
    dev_data_low = 1'b0;
    dev_frames++;
    dev_busy = 1'b0;
  endtask

  initial begin : device
    forever begin
      @(negedge vga_clk);
      if (!reset && dev_mode != DEV_NEVER && clk_line && !data_line) run_frame();
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        done;
    logic [10:0] bits;
    logic        chk;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e;
  logic last_pulse = 1'b0;
  int   n_pulses   = 0;

  always @(negedge vga_clk) begin
    if (!reset) begin
      if (last_pulse) check("pulse_width", {30'd0, tx_done, tx_err}, 32'd0);
      last_pulse = tx_done | tx_err;
      if (tx_done || tx_err) begin
        n_pulses++;
        check("done_err_exclusive", tx_done & tx_err, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, tx_done, tx_err}, 32'd0);
        end else begin
          cur_e = exp_q.pop_front();
          check("outcome_done", tx_done, cur_e.done);
          if (cur_e.chk) check("frame_bits", dev_bits, cur_e.bits);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge vga_clk);
    while ((!tx_ready || dev_busy) && n < 40000) begin
      @(negedge vga_clk);
      n++;
    end
    check(name, tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic push, input logic exp_done, input logic chk);
    wait_ready("ready_before_send");
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge vga_clk);
    if (push) exp_q.push_back('{exp_done, {1'b1, ~^d, d, 1'b0}, chk});
    #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  initial begin : global_guard
    #20ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int   n, t0, t1, t2, tr, te, frames_before;
    logic clk_dropped;

    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_err", tx_err, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    reset = 1'b0;

    // 0xED at 12.5 kHz, with inhibit / start-hold timing measured on the way
    half = 1000;
    send(8'hED, 1, 1, 1);
    @(negedge vga_clk);
    t0 = cyc;
    check("accept_clk_oe", ps2_clk_oe, 1);
    check("accept_ready_low", tx_ready, 0);
    n = 0;
    clk_dropped = 1'b0;
    while (!ps2_data_oe && n < 5000) begin
      if (!ps2_clk_oe) clk_dropped = 1'b1;
      @(negedge vga_clk);
      n++;
    end
    t1 = cyc;
    check("inhibit_len", t1 - t0, INHIBIT);
    check("clk_oe_through_inhibit", {clk_dropped, ps2_clk_oe}, 2'b01);
    n = 0;
    while (ps2_clk_oe && n < 5000) begin
      @(negedge vga_clk);
      n++;
    end
    t2 = cyc;
    check("start_hold_len", t2 - t1, HOLD);
    check("start_bit_held", ps2_data_oe, 1);
    wait_ready("ed_ready_again");

    // 0x00 then 0x01 with tx_valid held high across the first frame
    half = 50;
    frames_before = dev_frames;
    send(8'h00, 1, 1, 1);
    exp_q.push_back('{1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1});
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    n = 0;
    @(negedge vga_clk);
    while (!tx_ready && n < 40000) begin
      @(negedge vga_clk);
      n++;
    end
    check("b2b_first_done_before_ready", dev_frames, frames_before + 1);
    @(posedge vga_clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hAA;
    @(negedge vga_clk);
    check("b2b_second_accepted", tx_ready, 0);
    wait_ready("b2b_ready_again");

    // device never clocks: watchdog from clock release
    dev_mode = DEV_NEVER;
    send(8'h81, 1, 0, 0);
    n = 0;
    @(negedge vga_clk);
    while (!(!tx_ready && !ps2_clk_oe && ps2_data_oe) && n < 5000) begin
      @(negedge vga_clk);
      n++;
    end
    tr = cyc;
    n = 0;
    while (!tx_err && n < TMO + 100) begin
      @(negedge vga_clk);
      n++;
    end
    te = cyc;
    check("timeout_len", te - tr, TMO);
    check("timeout_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("timeout_ready", tx_ready, 1);
    dev_mode = DEV_ACK;

    // device leaves data high at the ack edge
    dev_mode = DEV_NACK;
    send(8'h5A, 1, 0, 1);
    wait_ready("nack_ready_again");
    dev_mode = DEV_ACK;

    // reset for one cycle mid-SEND after D3 has been driven
    stop_after  = 4;
    dev_aborted = 1'b0;
    send(8'h3C, 0, 0, 0);
    n = 0;
    while (!dev_aborted && n < 10000) begin
      @(negedge vga_clk);
      n++;
    end
    repeat (5) @(negedge vga_clk);
    check("pre_reset_busy", tx_ready, 0);
    check("pre_reset_d3", ps2_data_oe, 0);
    reset = 1'b1;
    @(negedge vga_clk);
    check("mid_reset_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("mid_reset_ready", tx_ready, 1);
    reset      = 1'b0;
    stop_after = 10;

    send(8'hFF, 1, 1, 1);
    wait_ready("ff_ready_again");

    repeat (5) @(negedge vga_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("pulse_count", n_pulses, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
